// File: rtl/uart_tx_fifo_feeder.sv
`timescale 1ns/1ps
// Circular byte FIFO that launches one frame at a time into the UART transmitter (DV/Active/Done).
// A write into an empty FIFO launches on the next edge; writes into a full FIFO are dropped with a one-cycle o_Overflow.
module uart_tx_fifo_feeder #(
    parameter int DEPTH          = 16,
    parameter int GAP_CLKS       = 0,
    parameter int ACTIVE_TIMEOUT = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     i_Wr_DV,
    input  logic [7:0]               i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow,
    output logic                     o_TX_DV,
    output logic [7:0]               o_TX_Byte,
    input  logic                     i_TX_Active,
    input  logic                     i_TX_Done,
    output logic                     o_Busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACTIVE_TIMEOUT + 1);
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam bit HAS_GAP = (GAP_CLKS > 0);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACTIVE_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH_WAIT,
        TX_WAIT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full_now;
    logic            wr_en;
    logic            pop;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        pop       = 1'b0;

        // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for the write.
        full_now  = (count_q == DEPTH_C);
        wr_en     = i_Wr_DV && !full_now;
        ovf_d     = i_Wr_DV && full_now;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && !i_TX_Active) begin
                    pop       = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                    tx_dv_d   = 1'b1;
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    tmo_d     = '0;
                    state_d   = LAUNCH_WAIT;
                end
            end
            LAUNCH_WAIT: begin
                if (i_TX_Active) begin
                    state_d = TX_WAIT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_q == TMO_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            TX_WAIT: begin
                if (i_TX_Done) begin
                    gap_d   = '0;
                    state_d = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            tmo_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    // Storage carries no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Busy     = (state_q != IDLE) || !empty_q;

endmodule
